pc_fetch_unit: RTL and testbench

- Sequencing counterpart to the ALU: consumes the ALU's branch-taken flag, resolved target address and overflow flag, and produces the program counter that drives instruction fetch.
- Supplies the active program's start address back to the ALU for label resolution.
- Handles program launch (start/done handshake), stalls, halt, a sticky overflow status and a retired-instruction counter.

---
 rtl/pc_fetch_unit_if.sv | 30 +++
 rtl/pc_fetch_unit.sv | 93 +++++++++
 tb/tb_pc_fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Bus between the program-counter sequencer and its environment (ALU, decoder, launch control).
// The sequencer takes the slave side; whatever drives launch and ALU results takes the master side.
interface pc_fetch_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 start_i;
  logic [1:0]           prog_sel_i;
  logic                 stall_i;
  logic                 branch_taken_i;
  logic [7:0]           target_i;
  logic                 halt_i;
  logic                 overflow_i;
  logic [7:0]           pc_o;
  logic [7:0]           startAddr_o;
  logic                 fetch_en_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 ovf_sticky_o;
  logic [CNT_WIDTH-1:0] instr_count_o;

  modport master (
    output start_i, prog_sel_i, stall_i, branch_taken_i, target_i, halt_i, overflow_i,
    input  pc_o, startAddr_o, fetch_en_o, busy_o, done_o, ovf_sticky_o, instr_count_o
  );

  modport slave (
    input  start_i, prog_sel_i, stall_i, branch_taken_i, target_i, halt_i, overflow_i,
    output pc_o, startAddr_o, fetch_en_o, busy_o, done_o, ovf_sticky_o, instr_count_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter sequencer: launches one of three programs, steps/branches the PC on
// each retired instruction, and tracks halt, sticky overflow and a retired-instruction count.
module pc_fetch_unit #(
  parameter logic [7:0] PROG0_START = 8'h00,
  parameter logic [7:0] PROG1_START = 8'h5E,
  parameter logic [7:0] PROG2_START = 8'hAB,
  parameter int         CNT_WIDTH   = 16
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [7:0]           pc_q, pc_d;
  logic [7:0]           start_q, start_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 launch_ok;
  logic [7:0]           launch_addr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    launch_ok   = 1'b1;
    launch_addr = PROG0_START;
    case (bus.prog_sel_i)
      2'd0:    launch_addr = PROG0_START;
      2'd1:    launch_addr = PROG1_START;
      2'd2:    launch_addr = PROG2_START;
      default: launch_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i && launch_ok) begin
          state_d = RUN;
          pc_d    = launch_addr;
          start_d = launch_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (!bus.stall_i) begin
          cnt_d = sat_inc(cnt_q);
          ovf_d = ovf_q | bus.overflow_i;
          // Halt outranks a branch so the PC parks on the terminating instruction.
          if (bus.halt_i)              state_d = DONE;
          else if (bus.branch_taken_i) pc_d    = bus.target_i;
          else                         pc_d    = pc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.startAddr_o   = start_q;
  assign bus.instr_count_o = cnt_q;
  assign bus.ovf_sticky_o  = ovf_q;
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = (state_q == DONE);
  assign bus.fetch_en_o    = (state_q == RUN) && !bus.stall_i;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table with a scoreboard queue, plus hand-written
// sequences for asynchronous reset and counter saturation on a narrow-counter instance.
module tb_pc_fetch_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.CNT_WIDTH(16)) bus ();
  pc_fetch_unit_if #(.CNT_WIDTH(3))  bus3 ();

  pc_fetch_unit #(.CNT_WIDTH(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  pc_fetch_unit #(.CNT_WIDTH(3))  dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  sa;
    logic        busy;
    logic        done;
    logic        sticky;
    logic        fen;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       stall;
    logic       br;
    logic [7:0] tgt;
    logic       halt;
    logic       ovf;
    exp_t       e;
  } vec_t;

  vec_t vecs[22];
  exp_t sbq[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic sl,
                              input logic br, input logic [7:0] tg, input logic h,
                              input logic o, input logic [7:0] pc, input logic [7:0] sa,
                              input logic b, input logic d, input logic s, input logic f,
                              input logic [15:0] c);
    vec_t v;
    v.start = st; v.sel = sel; v.stall = sl; v.br = br; v.tgt = tg; v.halt = h; v.ovf = o;
    v.e.pc = pc; v.e.sa = sa; v.e.busy = b; v.e.done = d; v.e.sticky = s; v.e.fen = f;
    v.e.cnt = c;
    return v;
  endfunction

  task automatic cmp_exp(input string tag, input exp_t e);
    chk({tag, " pc"},     16'(bus.pc_o),          16'(e.pc));
    chk({tag, " start"},  16'(bus.startAddr_o),   16'(e.sa));
    chk({tag, " busy"},   16'(bus.busy_o),        16'(e.busy));
    chk({tag, " done"},   16'(bus.done_o),        16'(e.done));
    chk({tag, " sticky"}, 16'(bus.ovf_sticky_o),  16'(e.sticky));
    chk({tag, " fetch"},  16'(bus.fetch_en_o),    16'(e.fen));
    chk({tag, " count"},  bus.instr_count_o,      e.cnt);
  endtask

  task automatic idle_inputs();
    bus.start_i = L; bus.prog_sel_i = 2'd0; bus.stall_i = L; bus.branch_taken_i = L;
    bus.target_i = 8'h00; bus.halt_i = L; bus.overflow_i = L;
    bus3.start_i = L; bus3.prog_sel_i = 2'd0; bus3.stall_i = L; bus3.branch_taken_i = L;
    bus3.target_i = 8'h00; bus3.halt_i = L; bus3.overflow_i = L;
  endtask

  exp_t rst_e;
  exp_t got;

  initial begin
    rst_e.pc = 8'h00; rst_e.sa = 8'h00; rst_e.busy = L; rst_e.done = L;
    rst_e.sticky = L; rst_e.fen = L; rst_e.cnt = 16'd0;

    //             st sel    sl br tgt    h  o   pc     sa     b  d  s  f  cnt
    vecs[0]  = mk(H, 2'd1, L, L, 8'h00, L, L, 8'h5E, 8'h5E, H, L, L, H, 16'd0);
    vecs[1]  = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h5F, 8'h5E, H, L, L, H, 16'd1);
    vecs[2]  = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h60, 8'h5E, H, L, L, H, 16'd2);
    vecs[3]  = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h61, 8'h5E, H, L, L, H, 16'd3);
    vecs[4]  = mk(L, 2'd0, L, H, 8'h70, L, L, 8'h70, 8'h5E, H, L, L, H, 16'd4);
    vecs[5]  = mk(L, 2'd0, H, H, 8'h88, L, L, 8'h70, 8'h5E, H, L, L, L, 16'd4);
    vecs[6]  = mk(L, 2'd0, L, H, 8'h88, L, L, 8'h88, 8'h5E, H, L, L, H, 16'd5);
    vecs[7]  = mk(L, 2'd0, H, L, 8'h00, H, H, 8'h88, 8'h5E, H, L, L, L, 16'd5);
    vecs[8]  = mk(H, 2'd2, L, L, 8'h00, L, L, 8'h89, 8'h5E, H, L, L, H, 16'd6);
    vecs[9]  = mk(L, 2'd0, L, H, 8'hA4, L, L, 8'hA4, 8'h5E, H, L, L, H, 16'd7);
    vecs[10] = mk(L, 2'd0, L, H, 8'h10, H, L, 8'hA4, 8'h5E, L, H, L, L, 16'd8);
    vecs[11] = mk(L, 2'd0, L, L, 8'h00, L, L, 8'hA4, 8'h5E, L, H, L, L, 16'd8);
    vecs[12] = mk(H, 2'd3, L, L, 8'h00, L, L, 8'hA4, 8'h5E, L, H, L, L, 16'd8);
    vecs[13] = mk(H, 2'd2, L, L, 8'h00, L, L, 8'hAB, 8'hAB, H, L, L, H, 16'd0);
    vecs[14] = mk(L, 2'd0, L, H, 8'hFE, L, L, 8'hFE, 8'hAB, H, L, L, H, 16'd1);
    vecs[15] = mk(L, 2'd0, L, L, 8'h00, L, H, 8'hFF, 8'hAB, H, L, H, H, 16'd2);
    vecs[16] = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h00, 8'hAB, H, L, H, H, 16'd3);
    vecs[17] = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h01, 8'hAB, H, L, H, H, 16'd4);
    vecs[18] = mk(L, 2'd0, L, L, 8'h00, H, L, 8'h01, 8'hAB, L, H, H, L, 16'd5);
    vecs[19] = mk(H, 2'd3, L, L, 8'h00, L, L, 8'h01, 8'hAB, L, H, H, L, 16'd5);
    vecs[20] = mk(H, 2'd0, L, L, 8'h00, L, L, 8'h00, 8'h00, H, L, L, H, 16'd0);
    vecs[21] = mk(L, 2'd0, L, L, 8'h00, L, L, 8'h01, 8'h00, H, L, L, H, 16'd1);

    idle_inputs();
    #2 reset = H;
    #1 cmp_exp("reset", rst_e);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = L;
    @(posedge clk); #1;
    cmp_exp("post-reset idle", rst_e);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus.start_i = vecs[i].start; bus.prog_sel_i = vecs[i].sel; bus.stall_i = vecs[i].stall;
      bus.branch_taken_i = vecs[i].br; bus.target_i = vecs[i].tgt;
      bus.halt_i = vecs[i].halt; bus.overflow_i = vecs[i].ovf;
      sbq.push_back(vecs[i].e);
      @(posedge clk); #1;
      got = sbq.pop_front();
      cmp_exp($sformatf("v%0d", i), got);
    end

    // Reset between edges while running, with a launch request held.
    @(negedge clk);
    idle_inputs();
    bus.start_i = H; bus.prog_sel_i = 2'd2;
    #2 reset = H;
    #1 cmp_exp("async reset", rst_e);
    repeat (2) @(posedge clk);
    #1 cmp_exp("reset held", rst_e);
    @(negedge clk) reset = L; bus.start_i = L;
    @(posedge clk); #1;
    cmp_exp("after reset", rst_e);

    // Narrow counter must saturate at all-ones.
    @(negedge clk);
    bus3.start_i = H; bus3.prog_sel_i = 2'd1;
    @(negedge clk);
    bus3.start_i = L;
    repeat (9) @(posedge clk);
    #1;
    chk("sat count", 16'(bus3.instr_count_o), 16'd7);
    chk("sat pc", 16'(bus3.pc_o), 16'h0067);
    chk("sat busy", 16'(bus3.busy_o), 16'd1);
    @(negedge clk) bus3.halt_i = H;
    @(posedge clk); #1;
    chk("sat halt done", 16'(bus3.done_o), 16'd1);
    chk("sat halt count", 16'(bus3.instr_count_o), 16'd7);
    chk("sat halt pc", 16'(bus3.pc_o), 16'h0067);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
